// File: rtl/stim_check_pkg.sv
// rtl/stim_check_pkg.sv - shared enums for the stimulus-and-check sequencer
package stim_check_pkg;

  typedef enum logic [1:0] {
    MODE_ALT   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/stim_pattern_gen.sv
// rtl/stim_pattern_gen.sv - pattern register: load vector 0 for a mode, then advance one step at a time
module stim_pattern_gen
  import stim_check_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             adv_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] pat_o
);

  logic [WIDTH-1:0] pat_q, pat_d;
  mode_e            mode_q, mode_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= '0;
      mode_q <= MODE_ALT;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    if (load_i) begin
      mode_d = mode_i;
      // WALK1 and LFSR both start from 1; ALT and COUNT start from 0
      pat_d  = (mode_i == MODE_WALK1 || mode_i == MODE_LFSR) ? WIDTH'(1) : '0;
    end else if (adv_i) begin
      case (mode_q)
        MODE_ALT:   pat_d = ~pat_q;
        MODE_COUNT: pat_d = pat_q + 1'b1;
        MODE_WALK1: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        MODE_LFSR:  pat_d = pat_q[0] ? ((pat_q >> 1) ^ TAPS) : (pat_q >> 1);
        default:    pat_d = pat_q;
      endcase
    end
  end

  assign pat_o = pat_q;

endmodule

// File: rtl/stim_check_seq.sv
// rtl/stim_check_seq.sv - run FSM: applies NVEC held vectors, checks responses, reports pass/errors
module stim_check_seq
  import stim_check_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               NVEC   = 16,
  parameter int               HOLD   = 2,
  parameter int               ERR_W  = 8,
  parameter int               INVERT = 1,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
  localparam int              IDX_W  = (NVEC > 1) ? $clog2(NVEC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] stim_o,
  input  logic [WIDTH-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  vec_q, vec_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic              fval_q, fval_d;
  logic              load, adv, mismatch;
  logic [WIDTH-1:0]  pat, expected;

  stim_pattern_gen #(.WIDTH(WIDTH), .TAPS(TAPS)) u_pat (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .adv_i  (adv),
    .mode_i (mode_e'(mode)),
    .pat_o  (pat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
    end
  end

  assign expected = (INVERT != 0) ? ~pat : pat;

  // Written as if/else so an unknown response falls into the mismatch branch
  always_comb begin
    if (resp_i == expected) mismatch = 1'b0;
    else                    mismatch = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fval_d  = fval_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
          hold_d  = '0;
          vec_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fval_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (hold_q == HOLD_W'(HOLD - 1)) begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!fval_q) begin
              fval_d = 1'b1;
              fidx_d = vec_q;
            end
          end
          if (vec_q == IDX_W'(NVEC - 1)) begin
            state_d = ST_DONE;
          end else begin
            vec_d  = vec_q + 1'b1;
            adv    = 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign pass            = done && (err_q == '0) && !fval_q;
  assign stim_o          = busy ? pat : '0;
  assign err_cnt         = err_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fval_q;

endmodule

// File: tb/tb_stim_check_seq.sv
// tb/tb_stim_check_seq.sv - scoreboard bench: WIDTH=4, NVEC=8, HOLD=2, LFSR taps 4'hC
module tb_stim_check_seq;

  typedef struct packed {
    logic [7:0] err;
    logic       pas;
    logic [2:0] idx;
    logic       val;
  } res_t;

  logic       clk = 1'b0;
  logic       rst, start, sstart;
  logic [1:0] mode, smode;
  logic [3:0] stim_o, resp, s_stim;
  logic       busy, done, pass, fval;
  logic [7:0] err_cnt;
  logic [2:0] fidx;
  logic       s_busy, s_done, s_pass, s_fval;
  logic [1:0] s_err;
  logic [2:0] s_fidx;
  int         lb;
  bit         chk_en;

  int total = 0;
  int bad   = 0;

  logic [3:0] tbl [4][8];
  logic [3:0] exp_vec [$];
  res_t       res_q [$];
  res_t       res2_q [$];

  always #5 clk = ~clk;

  assign resp = (lb == 0) ? ~stim_o : (lb == 1) ? (~stim_o & 4'hE) : 4'h0;

  stim_check_seq #(.WIDTH(4), .NVEC(8), .HOLD(2), .ERR_W(8), .INVERT(1), .TAPS(4'hC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stim_o(stim_o), .resp_i(resp),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(fidx), .first_err_valid(fval)
  );

  stim_check_seq #(.WIDTH(4), .NVEC(8), .HOLD(2), .ERR_W(2), .INVERT(1), .TAPS(4'hC)) dut_sat (
    .clk(clk), .rst(rst), .start(sstart), .mode(smode), .stim_o(s_stim), .resp_i(4'h0),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .first_err_idx(s_fidx), .first_err_valid(s_fval)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  int         vcnt = 0;
  bit         done_prev = 1'b0;
  logic [3:0] ev;
  res_t       er;

  always @(negedge clk) begin
    if (busy) begin
      if (chk_en && (vcnt % 2) == 0) begin
        if (exp_vec.size() == 0) check("vec_queue_empty", 1, 0);
        else begin
          ev = exp_vec.pop_front();
          check("stim_o", stim_o, ev);
        end
      end
      vcnt++;
    end else begin
      if (done && !done_prev && chk_en) begin
        check("done_latency", vcnt, 16);
        if (res_q.size() == 0) check("res_queue_empty", 1, 0);
        else begin
          er = res_q.pop_front();
          check("err_cnt", err_cnt, er.err);
          check("pass", pass, er.pas);
          check("first_err_idx", fidx, er.idx);
          check("first_err_valid", fval, er.val);
        end
      end
      vcnt = 0;
    end
    done_prev = done;
  end

  bit   s_done_prev = 1'b0;
  res_t sr;

  always @(negedge clk) begin
    if (s_done && !s_done_prev) begin
      if (res2_q.size() == 0) check("sat_queue_empty", 1, 0);
      else begin
        sr = res2_q.pop_front();
        check("sat_err_cnt", s_err, sr.err);
        check("sat_pass", s_pass, sr.pas);
        check("sat_first_err_idx", s_fidx, sr.idx);
        check("sat_first_err_valid", s_fval, sr.val);
      end
    end
    s_done_prev = s_done;
  end

  task automatic push_run(input int m, input res_t r);
    for (int i = 0; i < 8; i++) exp_vec.push_back(tbl[m][i]);
    res_q.push_back(r);
  endtask

  task automatic launch(input int m, input bit push, input res_t r);
    if (push) push_run(m, r);
    mode  = 2'(m);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, done, 1);
  endtask

  initial begin
    tbl[0] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    tbl[1] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    tbl[2] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    tbl[3] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE};
    rst = 1'b0; start = 1'b0; sstart = 1'b0; mode = 2'd0; smode = 2'd0;
    lb = 0; chk_en = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_stim_o", stim_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err_idx", fidx, 0);
    check("rst_first_err_valid", fval, 0);
    rst = 1'b1;
    @(negedge clk);

    lb = 0;
    launch(0, 1'b1, '{err: 8'd0, pas: 1'b1, idx: 3'd0, val: 1'b0});
    wait_done("alt_ideal");

    lb = 1;
    launch(0, 1'b1, '{err: 8'd4, pas: 1'b0, idx: 3'd0, val: 1'b1});
    wait_done("alt_stuck");

    lb = 0;
    launch(2, 1'b1, '{err: 8'd0, pas: 1'b1, idx: 3'd0, val: 1'b0});
    wait_done("walk1");
    launch(3, 1'b1, '{err: 8'd0, pas: 1'b1, idx: 3'd0, val: 1'b0});
    wait_done("lfsr");
    @(negedge clk);

    chk_en = 1'b0;
    lb = 1;
    launch(0, 1'b0, '0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_stim_o", stim_o, 0);
    check("abort_busy", busy, 0);
    check("abort_err_cnt", err_cnt, 0);
    check("abort_first_err_valid", fval, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    lb = 0;
    chk_en = 1'b1;
    @(negedge clk);
    launch(0, 1'b1, '{err: 8'd0, pas: 1'b1, idx: 3'd0, val: 1'b0});
    wait_done("after_reset");
    @(negedge clk);

    push_run(1, '{err: 8'd0, pas: 1'b1, idx: 3'd0, val: 1'b0});
    push_run(1, '{err: 8'd0, pas: 1'b1, idx: 3'd0, val: 1'b0});
    mode  = 2'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("held_first");
    @(posedge clk);
    #1 start = 1'b0;
    check("held_restart_busy", busy, 1);
    wait_done("held_second");
    @(negedge clk);

    res2_q.push_back('{err: 8'd3, pas: 1'b0, idx: 3'd0, val: 1'b1});
    smode  = 2'd1;
    sstart = 1'b1;
    @(posedge clk);
    #1 sstart = 1'b0;
    begin
      int n = 0;
      while (!s_done && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("sat_timeout", s_done, 1);

    repeat (2) @(negedge clk);
    check("vec_queue_drained", exp_vec.size(), 0);
    check("res_queue_drained", res_q.size(), 0);
    check("sat_queue_drained", res2_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
